// File: rtl/bd_tx_arbiter.sv
// Round-robin arbiter sharing the downstream serializer channel among NUM_IN
// d/v/a sources, with a per-grant burst cap and a software enable mask.
module bd_tx_arbiter #(
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned NUM_BITS  = 21,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IN-1:0]          in_v,
  input  logic [NUM_IN*NUM_BITS-1:0] in_d,
  output logic [NUM_IN-1:0]          in_a,
  input  logic [NUM_IN-1:0]          in_en,
  output logic                       out_v,
  output logic [NUM_BITS-1:0]        out_d,
  input  logic                       out_a,
  output logic                       grant_valid,
  output logic [$clog2(NUM_IN)-1:0]  grant_id,
  output logic                       protocol_err
);

  localparam int unsigned ID_W  = $clog2(NUM_IN);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              perr_q;

  logic [NUM_IN-1:0] req;
  logic              found;
  logic [ID_W-1:0]   pick;
  logic              g_v;
  logic [NUM_BITS-1:0] g_d;
  logic              ack;

  assign req = in_v & in_en;

  // First requester at or after rr_ptr, wrapping modulo NUM_IN.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_IN;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  assign g_v = in_v[grant_id_q];
  assign g_d = in_d[32'(grant_id_q)*NUM_BITS +: NUM_BITS];

  always_comb begin
    out_v       = 1'b0;
    out_d       = '0;
    grant_valid = 1'b0;
    if (state_q == GRANTED) begin
      out_v       = g_v;
      out_d       = g_d;
      grant_valid = 1'b1;
    end
  end

  // An ack with nothing offered is a protocol error, not a consumed word.
  assign ack      = out_a & out_v;
  assign grant_id = grant_id_q;

  always_comb begin
    in_a = '0;
    if (ack) in_a[grant_id_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d  = pick;
          burst_cnt_d = '0;
          state_d     = GRANTED;
        end
      end
      GRANTED: begin
        if (ack && (burst_cnt_q != CNT_W'(MAX_BURST - 1))) begin
          burst_cnt_d = CNT_W'(burst_cnt_q + 1'b1);
        end else if (ack || !g_v) begin
          rr_ptr_d    = ID_W'((32'(grant_id_q) + 1) % NUM_IN);
          grant_id_d  = '0;
          burst_cnt_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      if (out_a && !out_v) perr_q <= 1'b1;
    end
  end

  assign protocol_err = perr_q;

endmodule

// File: tb/tb_bd_tx_arbiter.sv
// Self-checking bench for bd_tx_arbiter: first-grant vector table plus
// scoreboarded multi-cycle scenarios on MAX_BURST=8 and MAX_BURST=1 instances.
module tb_bd_tx_arbiter;
  localparam int N = 4;
  localparam int W = 21;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]   in_v, in_en;
  logic [N*W-1:0] in_d;
  logic out_a0, out_a1;
  logic [N-1:0] in_a0, in_a1;
  logic ov0, ov1, gv0, gv1, pe0, pe1;
  logic [W-1:0] od0, od1;
  logic [1:0] gid0, gid1;

  always #5 clk = ~clk;

  bd_tx_arbiter #(.NUM_IN(N), .NUM_BITS(W), .MAX_BURST(8)) u_dut (
    .clk(clk), .reset(reset), .in_v(in_v), .in_d(in_d), .in_a(in_a0), .in_en(in_en),
    .out_v(ov0), .out_d(od0), .out_a(out_a0), .grant_valid(gv0), .grant_id(gid0),
    .protocol_err(pe0));

  bd_tx_arbiter #(.NUM_IN(N), .NUM_BITS(W), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_v(in_v), .in_d(in_d), .in_a(in_a1), .in_en(in_en),
    .out_v(ov1), .out_d(od1), .out_a(out_a1), .grant_valid(gv1), .grant_id(gid1),
    .protocol_err(pe1));

  int sel = 0;
  logic cur_ov, cur_gv, cur_pe;
  logic [W-1:0] cur_od;
  logic [1:0] cur_gid;
  logic [N-1:0] cur_in_a;
  assign cur_ov   = (sel == 1) ? ov1   : ov0;
  assign cur_gv   = (sel == 1) ? gv1   : gv0;
  assign cur_pe   = (sel == 1) ? pe1   : pe0;
  assign cur_od   = (sel == 1) ? od1   : od0;
  assign cur_gid  = (sel == 1) ? gid1  : gid0;
  assign cur_in_a = (sel == 1) ? in_a1 : in_a0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] word(input int i, input int k);
    return W'((i << 17) | ((k * 13 + 5) & 'h1FFFF));
  endfunction

  typedef struct {
    int          id;
    logic [W-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   exp_gr[$];
  int   got_gr[$];
  int   src_left[N];
  int   src_idx[N];
  int   push_idx[N];

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] en;
    logic         gv;
    int           gid;
  } vec_t;
  vec_t vt[7];

  task automatic drive_sources();
    for (int i = 0; i < N; i++) begin
      in_v[i]      = (src_left[i] > 0);
      in_d[i*W +: W] = (src_left[i] > 0) ? word(i, src_idx[i]) : '0;
    end
  endtask

  task automatic setup(input int a, input int b, input int c, input int d);
    src_left[0] = a; src_left[1] = b; src_left[2] = c; src_left[3] = d;
    for (int i = 0; i < N; i++) begin
      src_idx[i]  = 0;
      push_idx[i] = 0;
    end
    sb.delete();
    exp_gr.delete();
    got_gr.delete();
  endtask

  task automatic push_words(input int i, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.id = i;
      e.d  = word(i, push_idx[i]);
      push_idx[i]++;
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    in_v   = '0;
    in_en  = '0;
    in_d   = '0;
    out_a0 = 1'b0;
    out_a1 = 1'b0;
    #1;
    chk("rst_out_v", 32'(cur_ov), 0);
    chk("rst_grant_valid", 32'(cur_gv), 0);
    chk("rst_grant_id", 32'(cur_gid), 0);
    chk("rst_in_a", 32'(cur_in_a), 0);
    chk("rst_protocol_err", 32'(cur_pe), 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Serializer model acks after ser_delay extra cycles of out_v; sources pop on in_a.
  task automatic run(input int ncyc, input int ser_delay, input int en_after,
                     input logic [N-1:0] en_new);
    int acks = 0;
    int gap = 0;
    int last_id = -1;
    int vcnt = 0;
    logic prev_gv = 1'b0;
    logic oa;
    logic [N-1:0] acked;
    logic [N-1:0] exp_ia;
    exp_t e;
    repeat (ncyc) begin
      #1;
      if (cur_ov) begin
        vcnt++;
        oa = (vcnt > ser_delay);
      end else begin
        vcnt = 0;
        oa   = 1'b0;
      end
      if (sel == 1) out_a1 = oa; else out_a0 = oa;
      #1;
      acked = '0;
      if (cur_gv && !prev_gv) got_gr.push_back(int'(cur_gid));
      prev_gv = cur_gv;
      if (oa) begin
        vcnt = 0;
        exp_ia = '0;
        exp_ia[cur_gid] = 1'b1;
        chk("in_a_on_ack", 32'(cur_in_a), 32'(exp_ia));
        if (sb.size() > 0) begin
          e = sb.pop_front();
        end else begin
          e.id = -1;
          e.d  = '0;
        end
        chk("ack_src", 32'(cur_gid), e.id);
        chk("ack_data", 32'(cur_od), 32'(e.d));
        if (ser_delay == 0 && last_id >= 0 && int'(cur_gid) != last_id)
          chk("bubble", gap, 1);
        last_id = int'(cur_gid);
        gap = 0;
        acks++;
        acked = cur_in_a;
      end else begin
        chk("in_a_quiet", 32'(cur_in_a), 0);
        gap++;
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acked[i]) begin
          src_left[i]--;
          src_idx[i]++;
        end
      end
      drive_sources();
      if (acks == en_after) in_en = en_new;
    end
    out_a0 = 1'b0;
    out_a1 = 1'b0;
  endtask

  task automatic check_end();
    chk("sb_empty", sb.size(), 0);
    chk("grant_count", got_gr.size(), exp_gr.size());
    for (int i = 0; i < exp_gr.size(); i++)
      chk("grant_order", (i < got_gr.size()) ? got_gr[i] : -1, exp_gr[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    vt[0] = '{v: 4'b0100, en: 4'b1111, gv: 1'b1, gid: 2};
    vt[1] = '{v: 4'b1111, en: 4'b1010, gv: 1'b1, gid: 1};
    vt[2] = '{v: 4'b1000, en: 4'b1111, gv: 1'b1, gid: 3};
    vt[3] = '{v: 4'b0000, en: 4'b1111, gv: 1'b0, gid: 0};
    vt[4] = '{v: 4'b1111, en: 4'b0000, gv: 1'b0, gid: 0};
    vt[5] = '{v: 4'b1011, en: 4'b0110, gv: 1'b1, gid: 1};
    vt[6] = '{v: 4'b0101, en: 4'b1111, gv: 1'b1, gid: 0};

    // First arbitration after reset (rr_ptr=0).
    sel = 0;
    for (int j = 0; j < 7; j++) begin
      do_reset();
      in_v  = vt[j].v;
      in_en = vt[j].en;
      for (int i = 0; i < N; i++) in_d[i*W +: W] = word(i, 0);
      @(posedge clk); #1;
      chk("vec_grant_valid", 32'(cur_gv), 32'(vt[j].gv));
      chk("vec_grant_id", 32'(cur_gid), vt[j].gid);
      chk("vec_out_v", 32'(cur_ov), 32'(vt[j].gv));
      chk("vec_out_d", 32'(cur_od), vt[j].gv ? 32'(word(vt[j].gid, 0)) : 0);
    end

    // Protocol error in IDLE, then single-source transfer on the same run.
    do_reset();
    out_a0 = 1'b1;
    #1;
    chk("perr_no_in_a", 32'(in_a0), 0);
    chk("perr_before_edge", 32'(pe0), 0);
    @(posedge clk); #1;
    out_a0 = 1'b0;
    chk("perr_set", 32'(pe0), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("perr_sticky", 32'(pe0), 1);
    in_en = '1;
    in_v  = 4'b0100;
    in_d  = '0;
    in_d[2*W +: W] = 21'h1ABCD;
    #1;
    chk("ss_idle_out_v", 32'(ov0), 0);
    @(posedge clk); #1;
    chk("ss_grant_valid", 32'(gv0), 1);
    chk("ss_grant_id", 32'(gid0), 2);
    chk("ss_out_v", 32'(ov0), 1);
    chk("ss_out_d", 32'(od0), 32'h1ABCD);
    chk("ss_in_a_wait", 32'(in_a0), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_a0 = 1'b1;
    #1;
    chk("ss_in_a_pulse", 32'(in_a0), 32'b0100);
    @(posedge clk); #1;
    out_a0 = 1'b0;
    in_v   = '0;
    in_d   = '0;
    #1;
    chk("ss_hold_on_drop", 32'(gv0), 1);
    chk("ss_in_a_after", 32'(in_a0), 0);
    @(posedge clk); #1;
    chk("ss_released", 32'(gv0), 0);
    chk("ss_released_id", 32'(gid0), 0);
    chk("perr_still_set", 32'(pe0), 1);

    // Round robin, burst cap 8, serializer acks every cycle.
    sel = 0;
    do_reset();
    setup(16, 8, 8, 8);
    push_words(0, 8); push_words(1, 8); push_words(2, 8); push_words(3, 8); push_words(0, 8);
    exp_gr = '{0, 1, 2, 3, 0};
    in_en = '1;
    drive_sources();
    run(60, 0, -1, '0);
    check_end();

    // Burst cap 1: sources 0 and 3 strictly alternate.
    sel = 1;
    do_reset();
    setup(4, 0, 0, 4);
    for (int k = 0; k < 4; k++) begin
      push_words(0, 1);
      push_words(3, 1);
    end
    exp_gr = '{0, 3, 0, 3, 0, 3, 0, 3};
    in_en = '1;
    drive_sources();
    run(30, 0, -1, '0);
    check_end();
    chk("cap1_no_perr", 32'(pe1), 0);

    // Enable mask; in_en[1] cleared after 3 acks of source 1's burst.
    sel = 0;
    do_reset();
    setup(4, 16, 4, 16);
    push_words(1, 8); push_words(3, 8); push_words(3, 8);
    exp_gr = '{1, 3, 3};
    in_en = 4'b1010;
    drive_sources();
    run(45, 0, 3, 4'b1000);
    check_end();
    chk("en_src0_untouched", src_left[0], 4);
    chk("en_src2_untouched", src_left[2], 4);
    chk("en_src1_left", src_left[1], 8);

    // Asynchronous reset mid-burst of source 1 after 3 acks.
    sel = 0;
    do_reset();
    setup(0, 8, 0, 0);
    push_words(1, 3);
    exp_gr = '{1};
    in_en = '1;
    drive_sources();
    run(4, 0, -1, '0);
    check_end();
    chk("mid_granted", 32'(gv0), 1);
    out_a0 = 1'b1;
    reset  = 1'b1;
    #1;
    chk("mid_rst_out_v", 32'(ov0), 0);
    chk("mid_rst_in_a", 32'(in_a0), 0);
    chk("mid_rst_grant_valid", 32'(gv0), 0);
    chk("mid_rst_grant_id", 32'(gid0), 0);
    out_a0 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    setup(4, 4, 4, 4);
    drive_sources();
    @(posedge clk); #1;
    chk("post_rst_grant_valid", 32'(gv0), 1);
    chk("post_rst_grant_id", 32'(gid0), 0);
    chk("post_rst_perr", 32'(pe0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
